// File: rtl/insn_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, runs the imem req/ack handshake,
// holds the fetched word for decode, and kills in-flight fetches on redirect.
//
// state | meaning
// BOOT  | first cycle out of reset, no request yet
// FETCH | request outstanding at pc
// DROP  | request at pc still outstanding, its data will be discarded
// HOLD  | insn/insn_pc valid, waiting for decode to accept
// FAULT | misaligned fetch target, idle until redirected
module insn_fetch_ctrl #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] insn,
    output logic [63:0] insn_pc,
    output logic        insn_valid,
    input  logic        dec_ready,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    output logic        fetch_fault
);

    typedef enum logic [2:0] {
        BOOT  = 3'd0,
        FETCH = 3'd1,
        DROP  = 3'd2,
        HOLD  = 3'd3,
        FAULT = 3'd4
    } state_t;

    state_t      state, state_nxt;
    logic [63:0] pc, pc_nxt;
    logic [63:0] pend_pc, pend_pc_nxt;
    logic [63:0] drop_target;
    logic        load_insn;

    function automatic state_t target_state(input logic [63:0] target);
        return (target[1:0] == 2'b00) ? FETCH : FAULT;
    endfunction

    // pc is not updated while a killed fetch is in flight, so it is also the
    // outstanding address in DROP.
    assign imem_addr   = pc;
    assign drop_target = redirect ? redirect_pc : pend_pc;

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        pend_pc_nxt = pend_pc;
        load_insn   = 1'b0;
        case (state)
            BOOT: state_nxt = FETCH;
            FETCH: begin
                if (imem_ack) begin
                    if (redirect) begin
                        pc_nxt    = redirect_pc;
                        state_nxt = target_state(redirect_pc);
                    end else begin
                        load_insn = 1'b1;
                        state_nxt = HOLD;
                    end
                end else if (redirect) begin
                    pend_pc_nxt = redirect_pc;
                    state_nxt   = DROP;
                end
            end
            DROP: begin
                if (redirect) pend_pc_nxt = redirect_pc;
                if (imem_ack) begin
                    pc_nxt    = drop_target;
                    state_nxt = target_state(drop_target);
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_nxt    = redirect_pc;
                    state_nxt = target_state(redirect_pc);
                end else if (dec_ready) begin
                    pc_nxt    = pc + 64'(PC_STEP);
                    state_nxt = FETCH;
                end
            end
            FAULT: begin
                if (redirect) begin
                    pc_nxt    = redirect_pc;
                    state_nxt = target_state(redirect_pc);
                end
            end
            default: state_nxt = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            pend_pc     <= '0;
            insn        <= '0;
            insn_pc     <= '0;
            insn_valid  <= 1'b0;
            imem_req    <= 1'b0;
            fetch_fault <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            pend_pc     <= pend_pc_nxt;
            imem_req    <= (state_nxt == FETCH) || (state_nxt == DROP);
            insn_valid  <= (state_nxt == HOLD);
            fetch_fault <= (state_nxt == FAULT);
            if (load_insn) begin
                insn    <= imem_rdata;
                insn_pc <= pc;
            end
        end
    end

endmodule

// File: tb/tb_insn_fetch_ctrl.sv
// Directed bench for insn_fetch_ctrl; expected values are hand-derived per cycle.
module tb_insn_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] insn;
    logic [63:0] insn_pc;
    logic        insn_valid;
    logic        dec_ready;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        fetch_fault;

    int n_checks = 0;
    int n_errors = 0;

    insn_fetch_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .insn(insn), .insn_pc(insn_pc), .insn_valid(insn_valid),
        .dec_ready(dec_ready),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // request at addr, nothing handed to decode
    task automatic chk_req(input string tag, input logic [63:0] addr);
        chk({tag, " req"}, 64'(imem_req), 64'd1);
        chk({tag, " addr"}, imem_addr, addr);
        chk({tag, " valid"}, 64'(insn_valid), 64'd0);
        chk({tag, " fault"}, 64'(fetch_fault), 64'd0);
    endtask

    task automatic chk_hold(input string tag, input logic [31:0] w, input logic [63:0] p);
        chk({tag, " valid"}, 64'(insn_valid), 64'd1);
        chk({tag, " req"}, 64'(imem_req), 64'd0);
        chk({tag, " insn"}, 64'(insn), 64'(w));
        chk({tag, " insn_pc"}, insn_pc, p);
    endtask

    initial begin
        rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
        dec_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
        step(); step();
        chk("rst req", 64'(imem_req), 64'd0);
        chk("rst valid", 64'(insn_valid), 64'd0);
        chk("rst insn", 64'(insn), 64'd0);
        chk("rst insn_pc", insn_pc, 64'd0);
        chk("rst fault", 64'(fetch_fault), 64'd0);

        // release; redirect during BOOT must be ignored
        rst_n = 1'b1; redirect = 1'b1; redirect_pc = 64'h80;
        step();
        redirect = 1'b0;
        chk_req("boot", 64'h0);

        // zero-wait fetch at 0
        imem_ack = 1'b1; imem_rdata = 32'h00500093;
        step();
        chk_hold("t1", 32'h00500093, 64'h0);
        imem_ack = 1'b0; dec_ready = 1'b1;
        step();
        chk_req("t1 next", 64'h4);
        dec_ready = 1'b0;

        // three wait states, then decode stalls four cycles
        for (int i = 0; i < 3; i++) begin
            step();
            chk_req("t2 wait", 64'h4);
        end
        imem_ack = 1'b1; imem_rdata = 32'h00a00113;
        step();
        imem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk_hold("t2 stall", 32'h00a00113, 64'h4);
            step();
        end
        chk_hold("t2 stall end", 32'h00a00113, 64'h4);
        dec_ready = 1'b1;
        step();
        dec_ready = 1'b0;
        chk_req("t2 next", 64'h8);

        // redirect while fetch at 0x8 is pending
        redirect = 1'b1; redirect_pc = 64'h100;
        step();
        redirect = 1'b0;
        chk_req("t3 drop", 64'h8);
        step();
        chk_req("t3 drop2", 64'h8);
        imem_ack = 1'b1; imem_rdata = 32'hdeadbeef;
        step();
        imem_ack = 1'b0;
        chk_req("t3 new", 64'h100);
        chk("t3 insn kept", 64'(insn), 64'h00a00113);

        // two redirects in DROP, ack coincident with the second
        redirect = 1'b1; redirect_pc = 64'h200;
        step();
        chk_req("t4 drop", 64'h100);
        redirect_pc = 64'h300; imem_ack = 1'b1; imem_rdata = 32'h11111111;
        step();
        redirect = 1'b0; imem_ack = 1'b0;
        chk_req("t4 new", 64'h300);

        // redirect beats dec_ready in HOLD
        imem_ack = 1'b1; imem_rdata = 32'h00308193;
        step();
        imem_ack = 1'b0;
        chk_hold("t5 hold", 32'h00308193, 64'h300);
        redirect = 1'b1; redirect_pc = 64'h40; dec_ready = 1'b1;
        step();
        redirect = 1'b0; dec_ready = 1'b0;
        chk_req("t5 redir", 64'h40);
        chk("t5 insn kept", 64'(insn), 64'h00308193);
        imem_ack = 1'b1; imem_rdata = 32'h00408213;
        step();
        imem_ack = 1'b0;
        chk_hold("t5 hold2", 32'h00408213, 64'h40);
        dec_ready = 1'b1;
        step();
        dec_ready = 1'b0;
        chk_req("t5 next", 64'h44);

        // misaligned redirect (with ack in FETCH) -> FAULT; acks ignored there
        redirect = 1'b1; redirect_pc = 64'h102; imem_ack = 1'b1;
        step();
        redirect = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("t6 fault", 64'(fetch_fault), 64'd1);
            chk("t6 no req", 64'(imem_req), 64'd0);
            chk("t6 no valid", 64'(insn_valid), 64'd0);
            step();
        end
        imem_ack = 1'b0;
        chk("t6 fault held", 64'(fetch_fault), 64'd1);
        redirect = 1'b1; redirect_pc = 64'h104;
        step();
        redirect = 1'b0;
        chk_req("t6 recover", 64'h104);

        // PC wrap at top of address space
        redirect = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC; imem_ack = 1'b1;
        step();
        redirect = 1'b0;
        chk_req("t7 top", 64'hFFFF_FFFF_FFFF_FFFC);
        imem_rdata = 32'h00000013;
        step();
        imem_ack = 1'b0;
        chk_hold("t7 hold", 32'h00000013, 64'hFFFF_FFFF_FFFF_FFFC);
        dec_ready = 1'b1;
        step();
        dec_ready = 1'b0;
        chk_req("t7 wrap", 64'h0);

        // asynchronous reset mid-fetch
        #2 rst_n = 1'b0;
        #1;
        chk("t8 req", 64'(imem_req), 64'd0);
        chk("t8 insn", 64'(insn), 64'd0);
        chk("t8 insn_pc", insn_pc, 64'd0);
        chk("t8 valid", 64'(insn_valid), 64'd0);
        step();
        rst_n = 1'b1;
        step();
        chk_req("t8 reboot", 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
